// File: rtl/int_sequencer_pkg.sv
// Shared encodings for the interrupt/reset entry sequencer.
// Optional BRK entry (macro BRK_SEQ_EN) reuses the same kind encoding.
package int_sequencer_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;

    localparam logic [3:0] INTSEQ_IDLE     = 4'd0;
    localparam logic [3:0] INTSEQ_RST_HOLD = 4'd1;
    localparam logic [3:0] INTSEQ_DUMMY0   = 4'd2;
    localparam logic [3:0] INTSEQ_DUMMY1   = 4'd3;
    localparam logic [3:0] INTSEQ_PUSH_PCH = 4'd4;
    localparam logic [3:0] INTSEQ_PUSH_PCL = 4'd5;
    localparam logic [3:0] INTSEQ_PUSH_P   = 4'd6;
    localparam logic [3:0] INTSEQ_VEC_LO   = 4'd7;
    localparam logic [3:0] INTSEQ_VEC_HI   = 4'd8;
    localparam logic [3:0] INTSEQ_DONE     = 4'd9;

    typedef enum logic [1:0] {
        INT_RST = 2'd0,
        INT_NMI = 2'd1,
        INT_IRQ = 2'd2,
        INT_BRK = 2'd3
    } int_kind_t;

    localparam logic [7:0]  STACK_PAGE_DEF = 8'h01;
    localparam logic [15:0] VEC_NMI_DEF    = 16'hFFFA;
    localparam logic [15:0] VEC_RST_DEF    = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_DEF    = 16'hFFFE;

    // Pushed P always has bit5 set; bit4 distinguishes software BRK from hardware entry.
    function automatic logic [7:0] push_status(input logic [7:0] status, input logic brk);
        return {status[7:6], 1'b1, brk, status[3:0]};
    endfunction

endpackage

// File: rtl/int_sequencer_nmi_edge_detect.sv
// NMI falling-edge catcher: a 1->0 step on nmi_n sets pending until the sequencer clears it.
// A fresh edge in the same cycle as clear wins so that back-to-back NMIs are not lost.
module int_sequencer_nmi_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic nmi_n,
    input  logic clear,
    output logic pending
);

    logic nmi_prev_reg;
    logic pending_reg;
    logic fall;

    assign fall = nmi_prev_reg & ~nmi_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_prev_reg <= 1'b1;
            pending_reg  <= 1'b0;
        end else begin
            nmi_prev_reg <= nmi_n;
            if (fall) begin
                pending_reg <= 1'b1;
            end else if (clear) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/int_sequencer.sv
// Reset/NMI/IRQ entry sequencer: owns the bus for the push + vector fetch and hands back a new PC.
// Define BRK_SEQ_EN to add the brk_req input and run BRK entry here as well.
module int_sequencer
    import int_sequencer_pkg::*;
#(
    parameter logic [7:0]  STACK_PAGE = STACK_PAGE_DEF,
    parameter logic [15:0] VEC_NMI    = VEC_NMI_DEF,
    parameter logic [15:0] VEC_RST    = VEC_RST_DEF,
    parameter logic [15:0] VEC_IRQ    = VEC_IRQ_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  nmi_n,
    input  logic                  irq_n,
    input  logic                  i_flag,
    input  logic                  boundary,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [REG_WIDTH-1:0]  sp_in,
    input  logic [REG_WIDTH-1:0]  status_in,
    input  logic [REG_WIDTH-1:0]  data_in,
`ifdef BRK_SEQ_EN
    input  logic                  brk_req,
`endif
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [REG_WIDTH-1:0]  data_out,
    output logic                  r_w_n,
    output logic                  pc_we,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  sp_we,
    output logic [REG_WIDTH-1:0]  sp_out,
    output logic                  set_i
);

    logic [3:0]            state_reg, state_next;
    int_kind_t             kind_reg, kind_next;
    logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
    logic [REG_WIDTH-1:0]  sp_reg, sp_next;
    logic [REG_WIDTH-1:0]  stat_reg, stat_next;

    logic                  busy_reg, busy_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [REG_WIDTH-1:0]  data_out_reg, data_out_next;
    logic                  r_w_n_reg, r_w_n_next;
    logic                  strobe_reg, strobe_next;
    logic [ADDR_WIDTH-1:0] pc_out_reg;
    logic [REG_WIDTH-1:0]  sp_out_reg, sp_out_next;

    logic                  nmi_pend;
    logic                  nmi_clear;
    logic                  accept;
    int_kind_t             accept_kind;

    int_sequencer_nmi_edge_detect u_nmi_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .nmi_n   (nmi_n),
        .clear   (nmi_clear),
        .pending (nmi_pend)
    );

    function automatic logic [15:0] vec_base(input int_kind_t kind);
        case (kind)
            INT_NMI: return VEC_NMI;
            INT_RST: return VEC_RST;
            default: return VEC_IRQ;
        endcase
    endfunction

    always_comb begin
        state_next  = state_reg;
        kind_next   = kind_reg;
        pc_next     = pc_reg;
        sp_next     = sp_reg;
        stat_next   = stat_reg;
        nmi_clear   = 1'b0;
        accept      = 1'b0;
        accept_kind = INT_RST;

        case (state_reg)
            INTSEQ_RST_HOLD: begin
                accept      = 1'b1;
                accept_kind = INT_RST;
            end
            INTSEQ_IDLE: begin
                if (boundary) begin
                    if (nmi_pend) begin
                        accept      = 1'b1;
                        accept_kind = INT_NMI;
                        nmi_clear   = 1'b1;
                    end else if (!irq_n && !i_flag) begin
                        accept      = 1'b1;
                        accept_kind = INT_IRQ;
                    end
`ifdef BRK_SEQ_EN
                    else if (brk_req) begin
                        accept      = 1'b1;
                        accept_kind = INT_BRK;
                    end
`endif
                end
            end
            INTSEQ_DUMMY0, INTSEQ_DUMMY1, INTSEQ_PUSH_PCH,
            INTSEQ_PUSH_PCL, INTSEQ_PUSH_P: begin
                state_next = state_reg + 4'd1;
                // A late NMI steals the vector; what has been or will be pushed stays as latched.
                if (nmi_pend && (kind_reg == INT_IRQ || kind_reg == INT_BRK)) begin
                    kind_next = INT_NMI;
                    nmi_clear = 1'b1;
                end
            end
            INTSEQ_VEC_LO: state_next = INTSEQ_VEC_HI;
            INTSEQ_VEC_HI: state_next = INTSEQ_DONE;
            default:       state_next = INTSEQ_IDLE;
        endcase

        if (accept) begin
            state_next = INTSEQ_DUMMY0;
            kind_next  = accept_kind;
            pc_next    = (accept_kind == INT_BRK) ? pc_in + 16'd2 : pc_in;
            sp_next    = sp_in;
            stat_next  = push_status(status_in, accept_kind == INT_BRK);
        end
    end

    // Bus outputs are registered one state ahead so they are stable for the whole bus cycle.
    always_comb begin
        addr_next     = addr_reg;
        data_out_next = data_out_reg;
        r_w_n_next    = 1'b1;
        busy_next     = (state_next != INTSEQ_IDLE);
        strobe_next   = (state_next == INTSEQ_DONE);
        sp_out_next   = sp_out_reg;

        case (state_next)
            INTSEQ_DUMMY0, INTSEQ_DUMMY1: begin
                addr_next = pc_next;
            end
            INTSEQ_PUSH_PCH: begin
                addr_next     = {STACK_PAGE, sp_next};
                data_out_next = pc_next[15:8];
                r_w_n_next    = (kind_next == INT_RST);
            end
            INTSEQ_PUSH_PCL: begin
                addr_next     = {STACK_PAGE, sp_next - 8'd1};
                data_out_next = pc_next[7:0];
                r_w_n_next    = (kind_next == INT_RST);
            end
            INTSEQ_PUSH_P: begin
                addr_next     = {STACK_PAGE, sp_next - 8'd2};
                data_out_next = stat_next;
                r_w_n_next    = (kind_next == INT_RST);
            end
            INTSEQ_VEC_LO: begin
                addr_next = vec_base(kind_next);
            end
            INTSEQ_VEC_HI: begin
                addr_next = vec_base(kind_next) + 16'd1;
            end
            INTSEQ_DONE: begin
                sp_out_next = sp_next - 8'd3;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= INTSEQ_RST_HOLD;
            kind_reg     <= INT_RST;
            pc_reg       <= '0;
            sp_reg       <= '0;
            stat_reg     <= '0;
            busy_reg     <= 1'b1;
            addr_reg     <= '0;
            data_out_reg <= '0;
            r_w_n_reg    <= 1'b1;
            strobe_reg   <= 1'b0;
            pc_out_reg   <= '0;
            sp_out_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            kind_reg     <= kind_next;
            pc_reg       <= pc_next;
            sp_reg       <= sp_next;
            stat_reg     <= stat_next;
            busy_reg     <= busy_next;
            addr_reg     <= addr_next;
            data_out_reg <= data_out_next;
            r_w_n_reg    <= r_w_n_next;
            strobe_reg   <= strobe_next;
            sp_out_reg   <= sp_out_next;
            if (state_reg == INTSEQ_VEC_LO) begin
                pc_out_reg[7:0] <= data_in;
            end
            if (state_reg == INTSEQ_VEC_HI) begin
                pc_out_reg[15:8] <= data_in;
            end
        end
    end

    assign busy     = busy_reg;
    assign addr     = addr_reg;
    assign data_out = data_out_reg;
    assign r_w_n    = r_w_n_reg;
    assign pc_we    = strobe_reg;
    assign sp_we    = strobe_reg;
    assign set_i    = strobe_reg;
    assign pc_out   = pc_out_reg;
    assign sp_out   = sp_out_reg;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: reset entry, IRQ, masking, stack wrap, NMI hijack/level, mid-sequence reset.
module tb_int_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, nmi_n, irq_n, i_flag, boundary;
    logic [15:0] pc_in;
    logic [7:0]  sp_in, status_in, data_in;
`ifdef BRK_SEQ_EN
    logic        brk_req;
`endif
    logic        busy, r_w_n, pc_we, sp_we, set_i;
    logic [15:0] addr, pc_out;
    logic [7:0]  data_out, sp_out;

    logic [7:0]  mem [0:65535];
    assign data_in = mem[addr];

    always #5 clk = ~clk;

    int_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .i_flag    (i_flag),
        .boundary  (boundary),
        .pc_in     (pc_in),
        .sp_in     (sp_in),
        .status_in (status_in),
        .data_in   (data_in),
`ifdef BRK_SEQ_EN
        .brk_req   (brk_req),
`endif
        .busy      (busy),
        .addr      (addr),
        .data_out  (data_out),
        .r_w_n     (r_w_n),
        .pc_we     (pc_we),
        .pc_out    (pc_out),
        .sp_we     (sp_we),
        .sp_out    (sp_out),
        .set_i     (set_i)
    );

    int checks = 0;
    int passed = 0;

    // Observation record filled by watch()
    int          busy_cnt, we_cnt, we_idx, seti_cnt;
    logic [15:0] pc_at_we;
    logic [7:0]  sp_at_we;
    logic [15:0] bus_addr [16];
    logic [15:0] wr_addr [$];
    logic [7:0]  wr_data [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic watch(input int n, input int nmi_fall_idx);
        busy_cnt = 0; we_cnt = 0; we_idx = -1; seti_cnt = 0;
        pc_at_we = 16'h0; sp_at_we = 8'h0;
        wr_addr.delete(); wr_data.delete();
        for (int i = 0; i < 16; i++) bus_addr[i] = 16'h0;
        for (int i = 0; i < n; i++) begin
            if (i == nmi_fall_idx) nmi_n = 1'b0;
            if (busy) begin
                if (busy_cnt < 16) bus_addr[busy_cnt] = addr;
                busy_cnt++;
            end
            if (!r_w_n) begin
                wr_addr.push_back(addr);
                wr_data.push_back(data_out);
            end
            if (pc_we) begin
                we_cnt++; we_idx = i; pc_at_we = pc_out;
            end
            if (sp_we) sp_at_we = sp_out;
            if (set_i) seti_cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b1) $display("FAIL reset_busy got=%b want=1", busy); else passed++;
        checks++; if (addr !== 16'h0) $display("FAIL reset_addr got=%h want=0000", addr); else passed++;
        checks++; if (data_out !== 8'h0) $display("FAIL reset_data got=%h want=00", data_out); else passed++;
        checks++; if (r_w_n !== 1'b1) $display("FAIL reset_rwn got=%b want=1", r_w_n); else passed++;
        checks++; if ({pc_we, sp_we, set_i} !== 3'b000) $display("FAIL reset_strobes got=%b want=000", {pc_we, sp_we, set_i}); else passed++;
        checks++; if ({pc_out, sp_out} !== 24'h0) $display("FAIL reset_pc_sp got=%h want=000000", {pc_out, sp_out}); else passed++;
        sp_in = 8'hFD; pc_in = 16'h0000;
        reset_n = 1'b1;
        tick();
        watch(12, -1);
        $display("reset release: busy=%0d writes=%0d we_idx=%0d pc=%h sp=%h", busy_cnt, wr_addr.size(), we_idx, pc_at_we, sp_at_we);
        checks++; if (busy_cnt !== 8) $display("FAIL rst_busy_cycles got=%0d want=8", busy_cnt); else passed++;
        checks++; if (wr_addr.size() !== 0) $display("FAIL rst_no_writes got=%0d want=0", wr_addr.size()); else passed++;
        checks++; if (we_idx !== 7) $display("FAIL rst_pc_we_cycle got=%0d want=7", we_idx); else passed++;
        checks++; if (pc_at_we !== 16'h1234) $display("FAIL rst_pc_out got=%h want=1234", pc_at_we); else passed++;
        checks++; if (sp_at_we !== 8'hFA) $display("FAIL rst_sp_out got=%h want=FA", sp_at_we); else passed++;
        checks++; if (bus_addr[2] !== 16'h01FD) $display("FAIL rst_stack_read got=%h want=01FD", bus_addr[2]); else passed++;
        checks++; if ({bus_addr[5], bus_addr[6]} !== 32'hFFFCFFFD) $display("FAIL rst_vec_addr got=%h want=FFFCFFFD", {bus_addr[5], bus_addr[6]}); else passed++;
        checks++; if (seti_cnt !== 1) $display("FAIL rst_set_i got=%0d want=1", seti_cnt); else passed++;
    endtask

    task automatic test_irq();
        logic [15:0] ea [3];
        logic [7:0]  ed [3];
        ea = '{16'h01FF, 16'h01FE, 16'h01FD};
        ed = '{8'hC1, 8'h23, 8'h24};
        pc_in = 16'hC123; sp_in = 8'hFF; status_in = 8'h24;
        i_flag = 1'b0; irq_n = 1'b0; boundary = 1'b1;
        tick();
        boundary = 1'b0; irq_n = 1'b1;
        watch(12, -1);
        $display("irq: busy=%0d writes=%0d we_idx=%0d pc=%h sp=%h", busy_cnt, wr_addr.size(), we_idx, pc_at_we, sp_at_we);
        checks++; if (busy_cnt !== 8) $display("FAIL irq_busy_cycles got=%0d want=8", busy_cnt); else passed++;
        checks++; if (bus_addr[0] !== 16'hC123) $display("FAIL irq_dummy_addr got=%h want=C123", bus_addr[0]); else passed++;
        checks++;
        if (wr_addr.size() !== 3) $display("FAIL irq_write_count got=%0d want=3", wr_addr.size());
        else passed++;
        for (int i = 0; i < 3; i++) begin
            if (i < wr_addr.size()) begin
                checks++;
                if ({wr_addr[i], wr_data[i]} !== {ea[i], ed[i]})
                    $display("FAIL irq_push%0d got=%h:%h want=%h:%h", i, wr_addr[i], wr_data[i], ea[i], ed[i]);
                else passed++;
            end
        end
        checks++; if (pc_at_we !== 16'h8000) $display("FAIL irq_pc_out got=%h want=8000", pc_at_we); else passed++;
        checks++; if (sp_at_we !== 8'hFC) $display("FAIL irq_sp_out got=%h want=FC", sp_at_we); else passed++;
        checks++; if (seti_cnt !== 1) $display("FAIL irq_set_i got=%0d want=1", seti_cnt); else passed++;
    endtask

    task automatic test_irq_masked();
        int busy_seen = 0;
        irq_n = 1'b0; i_flag = 1'b1; boundary = 1'b1;
        tick();
        boundary = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_seen++;
            tick();
        end
        $display("irq masked: busy cycles=%0d", busy_seen);
        checks++; if (busy_seen !== 0) $display("FAIL irq_masked busy_cycles=%0d want=0", busy_seen); else passed++;
        i_flag = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_seen++;
            tick();
        end
        $display("irq without boundary: busy cycles=%0d", busy_seen);
        checks++; if (busy_seen !== 0) $display("FAIL irq_no_boundary busy_cycles=%0d want=0", busy_seen); else passed++;
        irq_n = 1'b1;
    endtask

    task automatic test_stack_wrap();
        logic [15:0] ea [3];
        logic [7:0]  ed [3];
        ea = '{16'h0101, 16'h0100, 16'h01FF};
        ed = '{8'h80, 8'h01, 8'h20};
        pc_in = 16'h8001; sp_in = 8'h01; status_in = 8'h00;
        irq_n = 1'b0; boundary = 1'b1;
        tick();
        boundary = 1'b0; irq_n = 1'b1;
        watch(12, -1);
        $display("stack wrap: writes=%0d sp=%h", wr_addr.size(), sp_at_we);
        checks++;
        if (wr_addr.size() !== 3) $display("FAIL wrap_write_count got=%0d want=3", wr_addr.size());
        else passed++;
        for (int i = 0; i < 3; i++) begin
            if (i < wr_addr.size()) begin
                checks++;
                if ({wr_addr[i], wr_data[i]} !== {ea[i], ed[i]})
                    $display("FAIL wrap_push%0d got=%h:%h want=%h:%h", i, wr_addr[i], wr_data[i], ea[i], ed[i]);
                else passed++;
            end
        end
        checks++; if (sp_at_we !== 8'hFE) $display("FAIL wrap_sp_out got=%h want=FE", sp_at_we); else passed++;
    endtask

    task automatic test_nmi_hijack();
        int busy_seen = 0;
        logic [15:0] ea [3];
        logic [7:0]  ed [3];
        ea = '{16'h01F0, 16'h01EF, 16'h01EE};
        ed = '{8'h45, 8'h67, 8'hA3};
        pc_in = 16'h4567; sp_in = 8'hF0; status_in = 8'h93;
        irq_n = 1'b0; boundary = 1'b1;
        tick();
        boundary = 1'b0; irq_n = 1'b1;
        watch(12, 1);
        nmi_n = 1'b1;
        $display("nmi hijack: vec=%h/%h pc=%h writes=%0d", bus_addr[5], bus_addr[6], pc_at_we, wr_addr.size());
        checks++; if ({bus_addr[5], bus_addr[6]} !== 32'hFFFAFFFB) $display("FAIL hijack_vec_addr got=%h want=FFFAFFFB", {bus_addr[5], bus_addr[6]}); else passed++;
        checks++; if (pc_at_we !== 16'h9000) $display("FAIL hijack_pc_out got=%h want=9000", pc_at_we); else passed++;
        checks++;
        if (wr_addr.size() !== 3) $display("FAIL hijack_write_count got=%0d want=3", wr_addr.size());
        else passed++;
        for (int i = 0; i < 3; i++) begin
            if (i < wr_addr.size()) begin
                checks++;
                if ({wr_addr[i], wr_data[i]} !== {ea[i], ed[i]})
                    $display("FAIL hijack_push%0d got=%h:%h want=%h:%h", i, wr_addr[i], wr_data[i], ea[i], ed[i]);
                else passed++;
            end
        end
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_seen++;
            tick();
        end
        $display("after hijack boundary: busy cycles=%0d", busy_seen);
        checks++; if (busy_seen !== 0) $display("FAIL hijack_pend_cleared busy_cycles=%0d want=0", busy_seen); else passed++;
    endtask

    task automatic test_nmi_level();
        int          seqs = 0;
        logic [15:0] pc_seen = 16'h0;
        irq_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            nmi_n    = (i < 20) ? 1'b0 : 1'b1;
            boundary = (i % 4 == 0);
            if (pc_we) begin
                seqs++; pc_seen = pc_out;
            end
            tick();
        end
        boundary = 1'b0;
        $display("nmi level: sequences=%0d pc=%h", seqs, pc_seen);
        checks++; if (seqs !== 1) $display("FAIL nmi_level_sequences got=%0d want=1", seqs); else passed++;
        checks++; if (pc_seen !== 16'h9000) $display("FAIL nmi_level_pc_out got=%h want=9000", pc_seen); else passed++;
    endtask

    task automatic test_reset_mid();
        int busy_seen = 0;
        pc_in = 16'hABCD; sp_in = 8'hFD; status_in = 8'h00;
        irq_n = 1'b0; boundary = 1'b1;
        tick();
        boundary = 1'b0; irq_n = 1'b1;
        tick(); tick();
        nmi_n = 1'b0;
        tick();
        checks++; if ({r_w_n, addr, data_out} !== {1'b0, 16'h01FC, 8'hCD}) $display("FAIL mid_pcl_cycle got=%b:%h:%h want=0:01FC:CD", r_w_n, addr, data_out); else passed++;
        reset_n = 1'b0;
        #1;
        $display("async reset: busy=%b addr=%h data=%h rwn=%b pc=%h", busy, addr, data_out, r_w_n, pc_out);
        checks++; if ({busy, r_w_n} !== 2'b11) $display("FAIL mid_reset_busy_rwn got=%b want=11", {busy, r_w_n}); else passed++;
        checks++; if ({addr, data_out} !== 24'h0) $display("FAIL mid_reset_bus got=%h want=000000", {addr, data_out}); else passed++;
        checks++; if ({pc_we, sp_we, set_i} !== 3'b000) $display("FAIL mid_reset_strobes got=%b want=000", {pc_we, sp_we, set_i}); else passed++;
        checks++; if ({pc_out, sp_out} !== 24'h0) $display("FAIL mid_reset_pc_sp got=%h want=000000", {pc_out, sp_out}); else passed++;
        nmi_n = 1'b1;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        watch(12, -1);
        $display("reset resequence: busy=%0d writes=%0d pc=%h sp=%h", busy_cnt, wr_addr.size(), pc_at_we, sp_at_we);
        checks++; if (wr_addr.size() !== 0) $display("FAIL mid_no_writes got=%0d want=0", wr_addr.size()); else passed++;
        checks++; if (busy_cnt !== 8) $display("FAIL mid_busy_cycles got=%0d want=8", busy_cnt); else passed++;
        checks++; if ({pc_at_we, sp_at_we} !== 24'h1234FA) $display("FAIL mid_pc_sp got=%h want=1234FA", {pc_at_we, sp_at_we}); else passed++;
        boundary = 1'b1;
        tick();
        boundary = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_seen++;
            tick();
        end
        $display("nmi lost across reset: busy cycles=%0d", busy_seen);
        checks++; if (busy_seen !== 0) $display("FAIL mid_nmi_lost busy_cycles=%0d want=0", busy_seen); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
        reset_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b0; boundary = 1'b0;
        pc_in = 16'h0; sp_in = 8'h0; status_in = 8'h0;
`ifdef BRK_SEQ_EN
        brk_req = 1'b0;
`endif
        test_reset();
        test_irq();
        test_irq_masked();
        test_stack_wrap();
        test_nmi_hijack();
        test_nmi_level();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
